// File: rtl/timer_peripheral_pkg.sv
// Shared constants for the memory-mapped timer/IO peripheral:
// register offsets, TCON bit positions and the default window base.
package periph_pkg;

  // Default word-aligned base of the 6-word register window.
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h4000_0000;

  // Byte offsets of each register inside the window.
  localparam logic [4:0] OFF_TH      = 5'h00;
  localparam logic [4:0] OFF_TL      = 5'h04;
  localparam logic [4:0] OFF_TCON    = 5'h08;
  localparam logic [4:0] OFF_LEDS    = 5'h0C;
  localparam logic [4:0] OFF_DIGITS  = 5'h10;
  localparam logic [4:0] OFF_SYSTICK = 5'h14;

  // TCON bit positions: enable, interrupt enable, interrupt status.
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  // Width of the implemented TCON bits; upper bits read as zero.
  localparam int TCON_W = 3;

  // Word index (addr[4:2]) corresponding to a byte offset.
  function automatic logic [2:0] word_of(input logic [4:0] off);
    return off[4:2];
  endfunction

endpackage

// File: rtl/timer_peripheral_if.sv
// CPU data-memory port as seen by the peripheral: address, store data and
// strobes from the CPU, decode hit and combinational read data back.
interface timer_peripheral_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic        hit;
  logic [31:0] rdata;

  // CPU side drives the access, observes hit/rdata.
  modport master (
    output addr, wdata, mem_read, mem_write,
    input  hit, rdata
  );

  // Peripheral side decodes the access and returns data.
  modport slave (
    input  addr, wdata, mem_read, mem_write,
    output hit, rdata
  );
endinterface

// File: rtl/timer_peripheral_timer_core.sv
// Reloadable 32-bit up-counter with reload register and interrupt status.
// Holds TH/TL/TCON; CPU writes arrive as per-register enables plus wdata.
module timer_core
  import periph_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we_th,
  input  logic              we_tl,
  input  logic              we_tcon,
  input  logic [31:0]       wdata,
  output logic [31:0]       th,
  output logic [31:0]       tl,
  output logic [TCON_W-1:0] tcon
);

  logic [31:0]       th_q, th_d;
  logic [31:0]       tl_q, tl_d;
  logic [TCON_W-1:0] tcon_q, tcon_d;
  logic              wrap;
  logic              set_is;

  // Next-state: count/reload first, then CPU writes override, then the
  // hardware status set is OR-ed in so it cannot be lost to a software clear.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    wrap   = tcon_q[TCON_EN] && (tl_q == 32'hFFFF_FFFF);
    // Status set uses the pre-write interrupt enable.
    set_is = wrap && tcon_q[TCON_IE];

    if (tcon_q[TCON_EN]) begin
      // Reload uses the old TH even if TH is written this cycle.
      tl_d = wrap ? th_q : tl_q + 32'd1;
    end

    if (we_th)   th_d   = wdata;
    if (we_tl)   tl_d   = wdata;
    if (we_tcon) tcon_d = wdata[TCON_W-1:0];

    if (set_is) tcon_d[TCON_IS] = 1'b1;
  end

  // Timer state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th   = th_q;
  assign tl   = tl_q;
  assign tcon = tcon_q;

endmodule

// File: rtl/timer_peripheral.sv
// Memory-mapped timer/IO peripheral: address decode of a 6-word window,
// zero-latency read mux, LED/7-segment output registers, free-running
// systick and the timer interrupt request.
module timer_peripheral
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  timer_peripheral_if.slave   bus,
  output logic                irq,
  output logic [7:0]          leds,
  output logic [11:0]         digits
);

  logic [2:0]        word_idx;
  logic              hit;
  logic              write_en;
  logic              we_th, we_tl, we_tcon, we_leds, we_digits;
  logic [31:0]       th, tl;
  logic [TCON_W-1:0] tcon;
  logic [7:0]        leds_q, leds_d;
  logic [11:0]       digits_q, digits_d;
  logic [31:0]       systick_q, systick_d;
  logic [31:0]       rdata;
  logic [1:0]        unused_byte_lane;

  // Byte-lane bits carry no meaning for word registers.
  assign unused_byte_lane = bus.addr[1:0];

  // Window decode: upper bits match the base, word index 0..5 only.
  always_comb begin
    word_idx = bus.addr[4:2];
    hit      = (bus.addr[31:5] == BASE_ADDR[31:5]) &&
               (word_idx <= word_of(OFF_SYSTICK));
  end

  // Per-register write enables; SYSTICK has none (read-only).
  always_comb begin
    write_en  = bus.mem_write && hit;
    we_th     = write_en && (word_idx == word_of(OFF_TH));
    we_tl     = write_en && (word_idx == word_of(OFF_TL));
    we_tcon   = write_en && (word_idx == word_of(OFF_TCON));
    we_leds   = write_en && (word_idx == word_of(OFF_LEDS));
    we_digits = write_en && (word_idx == word_of(OFF_DIGITS));
  end

  timer_core u_timer_core (
    .clk     (clk),
    .reset   (reset),
    .we_th   (we_th),
    .we_tl   (we_tl),
    .we_tcon (we_tcon),
    .wdata   (bus.wdata),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon)
  );

  // Next-state for IO registers and the free-running systick.
  always_comb begin
    leds_d    = we_leds   ? bus.wdata[7:0]  : leds_q;
    digits_d  = we_digits ? bus.wdata[11:0] : digits_q;
    systick_d = systick_q + 32'd1;
  end

  // IO and systick registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      leds_q    <= '0;
      digits_q  <= '0;
      systick_q <= '0;
    end else begin
      leds_q    <= leds_d;
      digits_q  <= digits_d;
      systick_q <= systick_d;
    end
  end

  // Read mux shows current (pre-write) register values, zero-extended.
  always_comb begin
    rdata = 32'h0;
    if (bus.mem_read && hit) begin
      case (word_idx)
        word_of(OFF_TH):      rdata = th;
        word_of(OFF_TL):      rdata = tl;
        word_of(OFF_TCON):    rdata = {{(32-TCON_W){1'b0}}, tcon};
        word_of(OFF_LEDS):    rdata = {24'h0, leds_q};
        word_of(OFF_DIGITS):  rdata = {20'h0, digits_q};
        word_of(OFF_SYSTICK): rdata = systick_q;
        default:              rdata = 32'h0;
      endcase
    end
  end

  assign bus.hit   = hit;
  assign bus.rdata = rdata;
  assign irq       = tcon[TCON_IE] & tcon[TCON_IS];
  assign leds      = leds_q;
  assign digits    = digits_q;

endmodule
